pulse_capture_queue: RTL and testbench

- Multi-channel successor to the single-LED pulse capture path.
- Each of N_CH asynchronous inputs is synchronised and rising-edge detected. Captured edges are queued in a per-channel saturating counter.
- Each queued edge is replayed as one output pulse: DELAY_CYCLES of delay, then ON_CYCLES high.
- Sits between board pins and LEDs/debug headers on the 100 MHz clk_wiz_0 domain.

---
 rtl/pulse_capture_queue.sv | 205 ++++++++++++++++++++
 tb/tb_pulse_capture_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_capture_queue.sv
// Multi-channel pulse capture queue: synchronise, edge-detect, count, and replay each
// captured edge as a delayed fixed-width pulse. Optional macro: PULSE_CAPTURE_QUEUE_OVERFLOW_EN.
module pulse_capture_queue #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DELAY_CYCLES = 100_000_000,
    parameter int ON_CYCLES    = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_i,
    output logic [N_CH-1:0]       pulse_o,
    output logic [N_CH-1:0]       busy_o,
    output logic [N_CH*CNT_W-1:0] pending_o,
    output logic [N_CH-1:0]       overflow_o
);

    localparam int MAX_CYC = (DELAY_CYCLES > ON_CYCLES) ? DELAY_CYCLES : ON_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    // Saturating up/down update; a capture at full scale with no consume is dropped.
    function automatic logic [CNT_W-1:0] pend_update(
        input logic [CNT_W-1:0] cur,
        input logic             cap,
        input logic             con
    );
        logic [CNT_W-1:0] res;
        if (cap && !con) begin
            if (cur == CNT_MAX) begin
                res = cur;
            end else begin
                res = cur + CNT_W'(1);
            end
        end else if (!cap && con) begin
            res = cur - CNT_W'(1);
        end else begin
            res = cur;
        end
        return res;
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [SYNC_STAGES-1:0] vld_r;
        logic                   prev_r;
        logic                   cap_s;
        logic                   consume_s;
        logic [CNT_W-1:0]       pend_r;
        logic [CNT_W-1:0]       pend_next_s;
        state_t                 state_r;
        state_t                 state_next_s;
        logic [TMR_W-1:0]       timer_r;
        logic [TMR_W-1:0]       timer_next_s;
        logic                   pulse_r;
        logic                   pulse_next_s;
        logic                   busy_r;

        // Synchroniser plus a fill marker so reset zeros never count as a sampled low.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_r <= {SYNC_STAGES{1'b0}};
                vld_r  <= {SYNC_STAGES{1'b0}};
                prev_r <= 1'b1;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], sig_i[c]};
                vld_r  <= {vld_r[SYNC_STAGES-2:0], 1'b1};
                if (vld_r[SYNC_STAGES-1]) begin
                    prev_r <= sync_r[SYNC_STAGES-1];
                end else begin
                    prev_r <= prev_r;
                end
            end
        end

        assign cap_s       = vld_r[SYNC_STAGES-1] & sync_r[SYNC_STAGES-1] & ~prev_r;
        assign pend_next_s = pend_update(pend_r, cap_s, consume_s);

        // State, timer, pending and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= ST_IDLE;
                timer_r <= {TMR_W{1'b0}};
                pend_r  <= CNT_ZERO;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                state_r <= state_next_s;
                timer_r <= timer_next_s;
                pend_r  <= pend_next_s;
                pulse_r <= pulse_next_s;
                busy_r  <= (state_next_s != ST_IDLE);
            end
        end

        // Next-state decode; the ON exit looks at the post-update pending value.
        always_comb begin
            state_next_s = state_r;
            case (state_r)
                ST_IDLE: begin
                    if (pend_r != CNT_ZERO) begin
                        state_next_s = ST_DELAY;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (timer_r == DLY_LAST) begin
                        state_next_s = ST_ON;
                    end else begin
                        state_next_s = ST_DELAY;
                    end
                end
                ST_ON: begin
                    if (timer_r == ON_LAST) begin
                        if (pend_next_s != CNT_ZERO) begin
                            state_next_s = ST_DELAY;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        state_next_s = ST_ON;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end

        // Timer, pulse level and consume strobe per state.
        always_comb begin
            timer_next_s = {TMR_W{1'b0}};
            pulse_next_s = 1'b0;
            consume_s    = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    timer_next_s = {TMR_W{1'b0}};
                    pulse_next_s = 1'b0;
                end
                ST_DELAY: begin
                    if (timer_r == DLY_LAST) begin
                        timer_next_s = {TMR_W{1'b0}};
                        pulse_next_s = 1'b1;
                    end else begin
                        timer_next_s = timer_r + TMR_W'(1);
                        pulse_next_s = 1'b0;
                    end
                end
                ST_ON: begin
                    if (timer_r == ON_LAST) begin
                        timer_next_s = {TMR_W{1'b0}};
                        pulse_next_s = 1'b0;
                        consume_s    = 1'b1;
                    end else begin
                        timer_next_s = timer_r + TMR_W'(1);
                        pulse_next_s = 1'b1;
                    end
                end
                default: begin
                    timer_next_s = {TMR_W{1'b0}};
                    pulse_next_s = 1'b0;
                    consume_s    = 1'b0;
                end
            endcase
        end

        assign pulse_o[c]                   = pulse_r;
        assign busy_o[c]                    = busy_r;
        assign pending_o[c*CNT_W +: CNT_W]  = pend_r;

`ifdef PULSE_CAPTURE_QUEUE_OVERFLOW_EN
        logic drop_s;
        logic ovf_r;

        assign drop_s = cap_s & ~consume_s & (pend_r == CNT_MAX);

        // Sticky dropped-capture flag, cleared only by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_r <= 1'b0;
            end else if (drop_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end

        assign overflow_o[c] = ovf_r;
`else
        assign overflow_o[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pulse_capture_queue.sv
// Directed self-checking bench for pulse_capture_queue (N_CH=2, CNT_W=2, DELAY=4, ON=3).
// Edge numbering per test: edge 1 is the first clock that samples the stimulus high.
module tb_pulse_capture_queue;

    localparam int N_CH = 2;
    localparam int CNT_W = 2;
`ifdef PULSE_CAPTURE_QUEUE_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N_CH-1:0]       sig_i = 2'b00;
    logic [N_CH-1:0]       pulse_o;
    logic [N_CH-1:0]       busy_o;
    logic [N_CH*CNT_W-1:0] pending_o;
    logic [N_CH-1:0]       overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_capture_queue #(
        .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .DELAY_CYCLES(4), .ON_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .sig_i(sig_i), .pulse_o(pulse_o),
        .busy_o(busy_o), .pending_o(pending_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive inputs for the next edge, then return to the following falling edge.
    task automatic step(input logic [1:0] s);
        sig_i = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sig_i = 2'b00;
        rst = 1'b1;
        step(2'b00);
        step(2'b00);
        rst = 1'b0;
        repeat (4) step(2'b00);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (pulse_o !== 2'b00) begin n_fail++; $display("FAIL reset_pulse got %b exp 00", pulse_o); end
        n_tests++;
        if (busy_o !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", busy_o); end
        n_tests++;
        if (pending_o !== 4'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", pending_o); end
        n_tests++;
        if (overflow_o !== 2'b00) begin n_fail++; $display("FAIL reset_overflow got %b exp 00", overflow_o); end
        @(negedge clk);
        step(2'b00);
        rst = 1'b0;
        repeat (4) step(2'b00);
        n_tests++;
        if ({pulse_o, busy_o, pending_o} !== 8'h00) begin
            n_fail++; $display("FAIL reset_idle got %h exp 00", {pulse_o, busy_o, pending_o});
        end
    endtask

    task automatic test_single();
        logic [3:0] ep;
        logic [1:0] eb, eq;
        for (int e = 1; e <= 12; e++) begin
            step((e == 1) ? 2'b01 : 2'b00);
            ep = (e >= 3 && e <= 10) ? 4'b0001 : 4'b0000;
            eb = (e >= 4 && e <= 10) ? 2'b01 : 2'b00;
            eq = (e >= 8 && e <= 10) ? 2'b01 : 2'b00;
            n_tests++;
            if (pending_o !== ep) begin n_fail++; $display("FAIL single_pend e=%0d got %h exp %h", e, pending_o, ep); end
            n_tests++;
            if (busy_o !== eb) begin n_fail++; $display("FAIL single_busy e=%0d got %b exp %b", e, busy_o, eb); end
            n_tests++;
            if (pulse_o !== eq) begin n_fail++; $display("FAIL single_pulse e=%0d got %b exp %b", e, pulse_o, eq); end
        end
    endtask

    // Shared expectation for three queued pulses, fourth capture (if any) dropped.
    task automatic run_three(input string name, input bit four);
        logic [3:0] ep;
        logic [1:0] eb, eq, eo;
        for (int e = 1; e <= 27; e++) begin
            step((e == 1 || e == 3 || e == 5 || (four && e == 7)) ? 2'b01 : 2'b00);
            if (e < 3) ep = 4'd0;
            else if (e < 5) ep = 4'd1;
            else if (e < 7) ep = 4'd2;
            else if (e < 11) ep = 4'd3;
            else if (e < 18) ep = 4'd2;
            else if (e < 25) ep = 4'd1;
            else ep = 4'd0;
            eb = (e >= 4 && e <= 24) ? 2'b01 : 2'b00;
            eq = ((e >= 8 && e <= 10) || (e >= 15 && e <= 17) || (e >= 22 && e <= 24)) ? 2'b01 : 2'b00;
            eo = (OVF_EN && four && e >= 9) ? 2'b01 : 2'b00;
            n_tests++;
            if (pending_o !== ep) begin n_fail++; $display("FAIL %s_pend e=%0d got %h exp %h", name, e, pending_o, ep); end
            n_tests++;
            if (busy_o !== eb) begin n_fail++; $display("FAIL %s_busy e=%0d got %b exp %b", name, e, busy_o, eb); end
            n_tests++;
            if (pulse_o !== eq) begin n_fail++; $display("FAIL %s_pulse e=%0d got %b exp %b", name, e, pulse_o, eq); end
            n_tests++;
            if (overflow_o !== eo) begin n_fail++; $display("FAIL %s_ovf e=%0d got %b exp %b", name, e, overflow_o, eo); end
        end
    endtask

    task automatic test_queue();
        do_reset();
        run_three("queue", 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        run_three("sat", 1'b1);
    endtask

    task automatic test_simul_consume();
        logic [3:0] ep;
        logic [1:0] eb, eq;
        do_reset();
        n_tests++;
        if (overflow_o !== 2'b00) begin n_fail++; $display("FAIL ovf_cleared got %b exp 00", overflow_o); end
        for (int e = 1; e <= 20; e++) begin
            step((e == 1 || e == 9) ? 2'b01 : 2'b00);
            ep = (e >= 3 && e < 18) ? 4'd1 : 4'd0;
            eb = (e >= 4 && e <= 17) ? 2'b01 : 2'b00;
            eq = ((e >= 8 && e <= 10) || (e >= 15 && e <= 17)) ? 2'b01 : 2'b00;
            n_tests++;
            if (pending_o !== ep) begin n_fail++; $display("FAIL simul_pend e=%0d got %h exp %h", e, pending_o, ep); end
            n_tests++;
            if (busy_o !== eb) begin n_fail++; $display("FAIL simul_busy e=%0d got %b exp %b", e, busy_o, eb); end
            n_tests++;
            if (pulse_o !== eq) begin n_fail++; $display("FAIL simul_pulse e=%0d got %b exp %b", e, pulse_o, eq); end
        end
    endtask

    task automatic test_reset_mid_on();
        do_reset();
        for (int e = 1; e <= 8; e++) step((e == 1) ? 2'b01 : 2'b00);
        n_tests++;
        if (pulse_o !== 2'b01) begin n_fail++; $display("FAIL midon_pre_pulse got %b exp 01", pulse_o); end
        sig_i = 2'b01;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (pulse_o !== 2'b00) begin n_fail++; $display("FAIL midon_pulse got %b exp 00", pulse_o); end
        n_tests++;
        if (pending_o !== 4'h0) begin n_fail++; $display("FAIL midon_pend got %h exp 0", pending_o); end
        n_tests++;
        if (busy_o !== 2'b00) begin n_fail++; $display("FAIL midon_busy got %b exp 00", busy_o); end
        @(negedge clk);
        step(2'b01);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(2'b01);
            n_tests++;
            if (pending_o !== 4'h0 || busy_o !== 2'b00) begin
                n_fail++; $display("FAIL held_high_capture e=%0d got pend %h busy %b exp 0 00", e, pending_o, busy_o);
            end
        end
        step(2'b00);
        step(2'b01);
        step(2'b00);
        step(2'b00);
        n_tests++;
        if (pending_o !== 4'h1) begin n_fail++; $display("FAIL recapture_pend got %h exp 1", pending_o); end
    endtask

    task automatic test_independence();
        logic [3:0] ep;
        logic [1:0] eb, eq;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step((e == 1) ? 2'b11 : ((e == 3) ? 2'b10 : 2'b00));
            ep[1:0] = (e >= 3 && e <= 10) ? 2'd1 : 2'd0;
            if (e < 3) ep[3:2] = 2'd0;
            else if (e < 5) ep[3:2] = 2'd1;
            else if (e < 11) ep[3:2] = 2'd2;
            else if (e < 18) ep[3:2] = 2'd1;
            else ep[3:2] = 2'd0;
            eb[0] = (e >= 4 && e <= 10);
            eb[1] = (e >= 4 && e <= 17);
            eq[0] = (e >= 8 && e <= 10);
            eq[1] = (e >= 8 && e <= 10) || (e >= 15 && e <= 17);
            n_tests++;
            if (pending_o !== ep) begin n_fail++; $display("FAIL indep_pend e=%0d got %h exp %h", e, pending_o, ep); end
            n_tests++;
            if (busy_o !== eb) begin n_fail++; $display("FAIL indep_busy e=%0d got %b exp %b", e, busy_o, eb); end
            n_tests++;
            if (pulse_o !== eq) begin n_fail++; $display("FAIL indep_pulse e=%0d got %b exp %b", e, pulse_o, eq); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_saturation();
        test_simul_consume();
        test_reset_mid_on();
        test_independence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
